// File: rtl/tick_scheduler.sv
// Programmable tick generator: emits a one-cycle tick every div_cur+1 cycles while running,
// with a handshaked divide-value reload that never disturbs a period already in progress.
module tick_scheduler #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   input  logic          stop,
   input  logic          div_req,
   input  logic [DW-1:0] div_val,
   output logic          div_ack,
   output logic          tick,
   output logic          half,
   output logic          busy
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] divCur_q, divCur_d;
   logic          tick_q, tick_d;
   logic          ack_q, ack_d;
   logic          half_q, half_d;
   logic          blocked_q, blocked_d;
   logic          loadOk;

   // blocked_q remembers a request that was already served (or cut off by reset)
   // until the requester drops div_req, so one request never yields two loads.
   assign loadOk = div_req & ~blocked_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         divCur_q  <= DW'(1);
         tick_q    <= 1'b0;
         ack_q     <= 1'b0;
         half_q    <= 1'b0;
         blocked_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         divCur_q  <= divCur_d;
         tick_q    <= tick_d;
         ack_q     <= ack_d;
         half_q    <= half_d;
         blocked_q <= blocked_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      divCur_d  = divCur_q;
      tick_d    = 1'b0;
      ack_d     = 1'b0;
      half_d    = half_q;
      blocked_d = blocked_q & div_req;
      case (state_q)
         IDLE: begin
            if (loadOk) begin
               divCur_d  = div_val;
               ack_d     = 1'b1;
               blocked_d = 1'b1;
            end
            if (start && !stop) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == divCur_q) begin
               // Terminal count is the only point where a reload may take effect.
               cnt_d  = '0;
               tick_d = 1'b1;
               half_d = ~half_q;
               if (loadOk) begin
                  divCur_d  = div_val;
                  ack_d     = 1'b1;
                  blocked_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + DW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign tick    = tick_q;
   assign div_ack = ack_q;
   assign half    = half_q;
   assign busy    = (state_q == RUN);

endmodule

// File: tb/tb_tick_scheduler.sv
// Testbench for tick_scheduler: directed scenarios followed by random traffic, each cycle
// compared against a cycles-since-last-tick reference model.
module tb_tick_scheduler;

   localparam int DW = 8;

   logic          clk     = 1'b0;
   logic          resetn  = 1'b1;
   logic          start   = 1'b0;
   logic          stop    = 1'b0;
   logic          div_req = 1'b0;
   logic [DW-1:0] div_val = '0;
   logic          div_ack;
   logic          tick;
   logic          half;
   logic          busy;

   int vectors     = 0;
   int miscompares = 0;

   bit mRun, mTick, mAck, mHalf, mBlocked;
   int mDiv, mSince;

   tick_scheduler #(.DW(DW)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .start   (start),
      .stop    (stop),
      .div_req (div_req),
      .div_val (div_val),
      .div_ack (div_ack),
      .tick    (tick),
      .half    (half),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic modelReset();
      mRun     = 1'b0;
      mTick    = 1'b0;
      mAck     = 1'b0;
      mHalf    = 1'b0;
      mBlocked = 1'b1;
      mDiv     = 1;
      mSince   = 0;
   endtask

   // Reference: a period is div+1 cycles; a tick closes each period; a request is
   // served once and must be withdrawn before another is honoured.
   task automatic modelEdge();
      bit loadOk;
      loadOk = div_req && !mBlocked;
      mTick  = 1'b0;
      mAck   = 1'b0;
      if (!div_req) mBlocked = 1'b0;
      if (!mRun) begin
         if (loadOk) begin
            mDiv     = int'(div_val);
            mAck     = 1'b1;
            mBlocked = 1'b1;
         end
         if (start && !stop) begin
            mRun   = 1'b1;
            mSince = 0;
         end
      end else if (stop) begin
         mRun = 1'b0;
      end else begin
         mSince++;
         if (mSince == mDiv + 1) begin
            mTick  = 1'b1;
            mHalf  = !mHalf;
            mSince = 0;
            if (loadOk) begin
               mDiv     = int'(div_val);
               mAck     = 1'b1;
               mBlocked = 1'b1;
            end
         end
      end
   endtask

   task automatic checkOutput(input string tag);
      vectors++;
      assert (tick === mTick) else begin
         miscompares++;
         $error("[TB] FAIL %s tick: observed %0b expected %0b", tag, tick, mTick);
      end
      vectors++;
      assert (div_ack === mAck) else begin
         miscompares++;
         $error("[TB] FAIL %s div_ack: observed %0b expected %0b", tag, div_ack, mAck);
      end
      vectors++;
      assert (half === mHalf) else begin
         miscompares++;
         $error("[TB] FAIL %s half: observed %0b expected %0b", tag, half, mHalf);
      end
      vectors++;
      assert (busy === mRun) else begin
         miscompares++;
         $error("[TB] FAIL %s busy: observed %0b expected %0b", tag, busy, mRun);
      end
   endtask

   task automatic applyStimulus(input string tag);
      @(posedge clk);
      if (!resetn) modelReset();
      else modelEdge();
      #1;
      checkOutput(tag);
   endtask

   initial begin
      modelReset();
      #2 resetn = 1'b0;
      #1 checkOutput("reset_async");
      applyStimulus("reset_hold");
      applyStimulus("reset_hold");
      resetn = 1'b1;
      applyStimulus("post_reset");
      applyStimulus("post_reset");

      $display("[TB] default divide: ticks every 2 cycles");
      start = 1'b1;
      applyStimulus("start_div1");
      start = 1'b0;
      for (int i = 0; i < 7; i++) applyStimulus("run_div1");

      stop = 1'b1;
      applyStimulus("stop_div1");
      stop = 1'b0;

      $display("[TB] idle reload to 3");
      div_val = DW'(3);
      div_req = 1'b1;
      applyStimulus("idle_load3");
      div_req = 1'b0;
      applyStimulus("idle_after_ack");
      start = 1'b1;
      applyStimulus("start_div3");
      start = 1'b0;
      for (int i = 0; i < 9; i++) applyStimulus("run_div3");

      $display("[TB] run reload to 0 at cnt 1");
      for (int i = 0; i < 8 && mSince != 1; i++) applyStimulus("seek_cnt1");
      div_val = DW'(0);
      div_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         applyStimulus("run_load0");
         if (mAck) break;
      end
      div_req = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus("run_div0");

      stop = 1'b1;
      applyStimulus("stop_div0");
      stop = 1'b0;

      $display("[TB] start with stop in idle");
      start = 1'b1;
      stop  = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus("start_and_stop");
      start = 1'b0;
      stop  = 1'b0;
      applyStimulus("idle_quiet");

      $display("[TB] stop on terminal count");
      div_val = DW'(2);
      div_req = 1'b1;
      applyStimulus("idle_load2");
      div_req = 1'b0;
      start = 1'b1;
      applyStimulus("start_div2");
      start = 1'b0;
      applyStimulus("run_div2");
      for (int i = 0; i < 6 && mSince != mDiv; i++) applyStimulus("seek_terminal");
      stop = 1'b1;
      applyStimulus("stop_terminal");
      stop = 1'b0;
      applyStimulus("idle_after_stop");

      $display("[TB] reset mid-period with request pending");
      start = 1'b1;
      applyStimulus("start_div2b");
      start = 1'b0;
      for (int i = 0; i < 6 && !mTick; i++) applyStimulus("seek_tick");
      div_val = DW'(5);
      div_req = 1'b1;
      applyStimulus("pending_req");
      #2 resetn = 1'b0;
      #1 modelReset();
      checkOutput("reset_mid");
      applyStimulus("reset_mid_hold");
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus("req_held_after_reset");
      div_req = 1'b0;
      applyStimulus("req_dropped");
      start = 1'b1;
      applyStimulus("start_after_reset");
      start = 1'b0;
      for (int i = 0; i < 6; i++) applyStimulus("run_after_reset");

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         if (!div_req && $urandom_range(0, 7) == 0) begin
            div_val = DW'($urandom_range(0, 5));
            div_req = 1'b1;
         end
         start = ($urandom_range(0, 5) == 0);
         stop  = ($urandom_range(0, 11) == 0);
         applyStimulus("random");
         if (mAck) div_req = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 The block SHALL have parameter: DW, 8, width of divide-value field and cycle counter.
REQ-002 The block SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 The block SHALL have port: resetn  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port: start  input  1  level-sampled request to begin ticking.
REQ-005 The block SHALL have port: stop  input  1  level-sampled request to halt ticking.
REQ-006 The block SHALL have port: div_req  input  1  request to load a new divide value; held until div_ack.
REQ-007 The block SHALL have port: div_val  input  DW  new divide value; must be stable while div_req is high; tick period = div_val+1 cycles.
REQ-008 The block SHALL have port: div_ack  output  1  one-cycle pulse; new value is in effect.
REQ-009 The block SHALL have port: tick  output  1  one-cycle enable pulse at each terminal count.
REQ-010 The block SHALL have port: half  output  1  toggles on every tick; 50% duty square wave at half the tick rate.
REQ-011 The block SHALL have port: busy  output  1  high in RUN state.

Function
REQ-012 The FSM SHALL have two states: IDLE and RUN.
REQ-013 IDLE SHALL move to RUN on start=1 and stop=0; simultaneous start and stop SHALL leave it in IDLE.
REQ-014 RUN SHALL move to IDLE on stop=1, on the same edge, with no tick on that edge.
REQ-015 Entering RUN SHALL clear cnt to 0; the first tick SHALL occur div_cur+1 cycles after the start edge.
REQ-016 In RUN, cnt SHALL increment each cycle; at cnt==div_cur it SHALL wrap to 0 and tick SHALL assert for exactly that cycle.
REQ-017 When div_cur=0, tick SHALL assert every RUN cycle, and half SHALL toggle every cycle.
REQ-018 cnt arithmetic SHALL be DW-bit unsigned; cnt SHALL never exceed div_cur.
REQ-019 tick and div_ack SHALL be registered outputs; busy SHALL be combinational from the state register.
REQ-020 In IDLE, with div_req=1, div_cur SHALL load div_val on the next edge, and div_ack SHALL pulse on that edge.
REQ-021 In RUN, with div_req=1, div_cur SHALL load only on the terminal-count edge; div_ack SHALL pulse on that same edge; the current period SHALL complete unaltered.
REQ-022 div_ack SHALL never pulse twice for one request; after div_ack, a new load SHALL require div_req low for at least one cycle and then high again.
REQ-023 A stop arriving while a RUN-mode div_req is pending SHALL cause the load to complete as in REQ-020 on the next IDLE edge.
REQ-024 half SHALL hold its value in IDLE and across stop/start, with no reset on restart.

Reset
REQ-025 With resetn=0, the block SHALL immediately force: state=IDLE, cnt=0, div_cur=1, tick=0, div_ack=0, half=0, busy=0.
REQ-026 Reset deassertion SHALL take effect synchronously at the next clk edge; reset mid-period SHALL discard any pending div_req.

Verification
REQ-027 The bench SHALL check: reset, then start=1 for one cycle -> tick on cycles 2, 4, 6 after start; half toggles 0->1->0->1.
REQ-028 The bench SHALL check: in IDLE, div_req=1 with div_val=3 -> div_ack on the next edge; after start, tick period = 4 cycles.
REQ-029 The bench SHALL check: in RUN with div_cur=3, div_req with div_val=0 at cnt=1 -> tick and div_ack at cnt=3 together; then tick every cycle.
REQ-030 The bench SHALL check: start and stop high together in IDLE -> busy stays 0 and no tick.
REQ-031 The bench SHALL check: stop at cnt==div_cur -> no tick; busy=0 next cycle; half unchanged.
REQ-032 The bench SHALL check: resetn low mid-period with div_req pending -> all outputs 0 immediately; div_cur=1; no div_ack after release.
